// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS core: opcodes, functs, FSM states
// and the ALU operation set with its evaluation function.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  function automatic logic [31:0] alu_calc(input alu_op_e op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
      default: return a + b;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// Architectural register file: two operand read ports, a debug read port and
// one write port. Index 0 and indices beyond NREGS read as zero and ignore writes.
module mips_mc_regfile #(
  parameter int NREGS = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  input  logic [4:0]  i_dbg_raddr,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2,
  output logic [31:0] o_dbg_rdata
);
  localparam int AW = $clog2(NREGS);
  localparam logic [5:0] NR = 6'(NREGS);

  logic [31:0] r_regs [NREGS];

  function automatic logic in_range(input logic [4:0] a);
    return (a != 5'd0) && ({1'b0, a} < NR);
  endfunction

  assign o_rdata1    = in_range(i_raddr1)    ? r_regs[i_raddr1[AW-1:0]]    : '0;
  assign o_rdata2    = in_range(i_raddr2)    ? r_regs[i_raddr2[AW-1:0]]    : '0;
  assign o_dbg_rdata = in_range(i_dbg_raddr) ? r_regs[i_dbg_raddr[AW-1:0]] : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_we && in_range(i_waddr)) begin
      r_regs[i_waddr[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core: controller FSM, datapath registers and ALU sharing one
// unified instruction/data memory port. Faults and halts are sticky until reset.
module mips_multicycle_core
  import mips_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        halted,
  output logic        fault,
  output logic        retire,
  output logic [31:0] pc_out,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata,
  output logic [2:0]  dbg_state
);
  localparam logic [5:0] NR   = 6'(NREGS);
  localparam logic [4:0] LINK = 5'(NREGS - 1);

  state_e      r_state, w_next;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_t, r_alu_out, r_mdr;
  logic        r_fault, w_set_fault, w_legal, w_taken;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata, w_rd1, w_rd2, w_alu_b, w_alu_y;
  alu_op_e     w_alu_op;

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [31:0] w_imm, w_ea, w_jump_tgt;
  logic        w_unused;

  assign w_op       = r_ir[31:26];
  assign w_rs       = r_ir[25:21];
  assign w_rt       = r_ir[20:16];
  assign w_rd       = r_ir[15:11];
  assign w_funct    = r_ir[5:0];
  assign w_imm      = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_ea       = r_a + w_imm;
  assign w_jump_tgt = {r_pc[31:28], r_ir[25:0], 2'b00};
  assign w_taken    = ((w_op == OP_BEQ) && (r_a == r_b)) || ((w_op == OP_BNE) && (r_a != r_b));
  assign w_unused   = ^r_ir[10:6];

  assign halted    = (r_state == HALT);
  assign fault     = r_fault;
  assign pc_out    = r_pc;
  assign dbg_state = r_state;

  mips_mc_regfile #(.NREGS(NREGS)) u_regfile (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_raddr1    (w_rs),
    .i_raddr2    (w_rt),
    .i_dbg_raddr (dbg_raddr),
    .i_we        (w_rf_we),
    .i_waddr     (w_rf_waddr),
    .i_wdata     (w_rf_wdata),
    .o_rdata1    (w_rd1),
    .o_rdata2    (w_rd2),
    .o_dbg_rdata (dbg_rdata)
  );

  always_comb begin
    w_legal = 1'b0;
    case (w_op)
      OP_RTYPE: w_legal = ({1'b0, w_rs} < NR) && ({1'b0, w_rt} < NR) && ({1'b0, w_rd} < NR) &&
                          (w_funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_JR});
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: w_legal = ({1'b0, w_rs} < NR) && ({1'b0, w_rt} < NR);
      OP_J, OP_JAL: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_alu_op = ALU_ADD;
    w_alu_b  = w_imm;
    if (w_op == OP_RTYPE) begin
      w_alu_b = r_b;
      case (w_funct)
        F_SUB:   w_alu_op = ALU_SUB;
        F_AND:   w_alu_op = ALU_AND;
        F_OR:    w_alu_op = ALU_OR;
        F_SLT:   w_alu_op = ALU_SLT;
        default: w_alu_op = ALU_ADD;
      endcase
    end
  end
  assign w_alu_y = alu_calc(w_alu_op, r_a, w_alu_b);

  // Memory handshake: mem_req with mem_addr/mem_we/mem_wdata held stable until a
  // rising edge sees mem_req && mem_ready; that edge completes the transfer.
  always_comb begin
    w_next      = r_state;
    w_set_fault = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = r_pc;
    mem_wdata   = r_b;
    retire      = 1'b0;
    w_rf_we     = 1'b0;
    w_rf_waddr  = w_rd;
    w_rf_wdata  = r_alu_out;
    case (r_state)
      FETCH: if (rst) begin
        if (r_pc[1:0] != 2'b00) begin
          w_next      = HALT;
          w_set_fault = 1'b1;
        end else begin
          mem_req = 1'b1;
          if (mem_ready) w_next = DECODE;
        end
      end
      DECODE: begin
        if (w_legal) begin
          w_next = EXEC;
        end else begin
          w_next      = HALT;
          w_set_fault = 1'b1;
        end
      end
      EXEC: begin
        case (w_op)
          OP_LW, OP_SW: begin
            if (w_ea[1:0] != 2'b00) begin
              w_next      = HALT;
              w_set_fault = 1'b1;
            end else begin
              w_next = MEM;
            end
          end
          OP_BEQ, OP_BNE, OP_J: begin
            retire = 1'b1;
            w_next = FETCH;
          end
          OP_JAL: begin
            retire     = 1'b1;
            w_next     = FETCH;
            w_rf_we    = 1'b1;
            w_rf_waddr = LINK;
            w_rf_wdata = r_pc;
          end
          OP_RTYPE: begin
            if (w_funct == F_JR) begin
              retire = 1'b1;
              w_next = FETCH;
            end else begin
              w_next = WB;
            end
          end
          default: w_next = WB;
        endcase
      end
      MEM: begin
        mem_req  = 1'b1;
        mem_we   = (w_op == OP_SW);
        mem_addr = r_alu_out;
        if (mem_ready) begin
          if (w_op == OP_SW) begin
            retire = 1'b1;
            w_next = FETCH;
          end else begin
            w_next = WB;
          end
        end
      end
      WB: begin
        retire     = 1'b1;
        w_next     = FETCH;
        w_rf_we    = 1'b1;
        w_rf_waddr = (w_op == OP_RTYPE) ? w_rd : w_rt;
        w_rf_wdata = (w_op == OP_LW) ? r_mdr : r_alu_out;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_t       <= '0;
      r_alu_out <= '0;
      r_mdr     <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_fault) r_fault <= 1'b1;
      case (r_state)
        FETCH: if (mem_req && mem_ready) begin
          r_ir <= mem_rdata;
          r_pc <= r_pc + 32'd4;
        end
        DECODE: begin
          r_a <= w_rd1;
          r_b <= w_rd2;
          r_t <= r_pc + {w_imm[29:0], 2'b00};
        end
        EXEC: begin
          r_alu_out <= ((w_op == OP_LW) || (w_op == OP_SW)) ? w_ea : w_alu_y;
          if (w_taken) r_pc <= r_t;
          else if ((w_op == OP_J) || (w_op == OP_JAL)) r_pc <= w_jump_tgt;
          else if ((w_op == OP_RTYPE) && (w_funct == F_JR)) r_pc <= r_a;
        end
        MEM: if (mem_ready && (w_op == OP_LW)) r_mdr <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Multicycle MIPS core. It merges the datapath and the controller FSM into one block that shares a single unified instruction/data memory port with a req/ready handshake, so wait states are tolerated.
- Successor to the single-cycle datapath, with these additions: a parametrised register count and reset vector, a stall-capable memory interface, a sticky fault/halt, and a debug register read port.
- Sits between the memory subsystem and the top level. It replaces the single-cycle datapath plus its separate controllers.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NREGS, 32, number of architectural registers; power of 2, 8..32. Any rs/rt/rd index >= NREGS is a fault. The link register is NREGS-1.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; one clock; asynchronous, active-low.
mem_req  out  1  memory request; held until accepted.
mem_we  out  1  1 = store, 0 = load/fetch.
mem_addr  out  32  byte address, word-aligned.
mem_wdata  out  32  store data.
mem_rdata  in  32  read data; valid when mem_req && mem_ready.
mem_ready  in  1  transfer completes on a clk edge where mem_req && mem_ready.
halted  out  1  sticky; core stopped.
fault  out  1  sticky; halted because of an illegal opcode, illegal register index or misaligned access.
retire  out  1  one-cycle pulse in the final cycle of each completed instruction.
pc_out  out  32  current PC.
dbg_raddr  in  5  debug register index.
dbg_rdata  out  32  combinational read of register dbg_raddr; reads 0 for index 0 or index >= NREGS.

Behaviour:
- Reset (rst low, async):
  - state=FETCH, pc=RESET_PC, all registers 0.
  - mem_req=0, mem_we=0, halted=0, fault=0, retire=0.
  - Any in-flight memory request is abandoned immediately.
- Register 0 always reads 0; writes to it are dropped.
- Supported instructions:
  - R-type (op 000000) funct: add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed), jr 001000.
  - I/J-type: addi 001000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011.
  - All arithmetic is 32-bit wraparound; no overflow trap.
- FSM states and actions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. Hold until accepted. On accept: IR<=mem_rdata, pc<=pc+4.
  - DECODE: A<=R[rs], B<=R[rt], T<=pc+(sext(imm)<<2). Illegal opcode, illegal funct or register index >= NREGS -> HALT with fault=1.
  - EXEC:
    - R-type/addi: ALUOut<=result -> WB.
    - lw/sw: ALUOut<=A+sext(imm). If ALUOut[1:0]!=0 -> HALT with fault. Otherwise -> MEM.
    - beq/bne: if taken, pc<=T -> FETCH (retire).
    - j: pc<={pc[31:28],imm26,2'b00} -> FETCH (retire).
    - jal: same as j, and R[NREGS-1]<=pc (already +4) -> FETCH (retire).
    - jr: pc<=A -> FETCH (retire).
  - MEM: mem_req=1, mem_addr=ALUOut, mem_we=sw, mem_wdata=B. Hold until accepted.
    - On accept for sw -> FETCH (retire).
    - On accept for lw: MDR<=mem_rdata -> WB.
  - WB: R[rd] for R-type, R[rt] for addi/lw -> FETCH (retire).
  - HALT: mem_req=0, halted=1. Exits only on reset.
- mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and no handshake has occurred.
- Latencies with zero wait states (ready=1): branch/j/jal/jr 3 cycles, R-type/addi/sw 4, lw 5. Each wait cycle adds 1.
- A jr whose target is misaligned is not checked at jr; the following fetch of the misaligned pc -> HALT with fault, no memory request issued.
- pc wraps modulo 2^32.
- If a WB register write and a dbg read hit the same index in the same cycle, dbg_rdata shows the old value.

Decomposition:
- Package mips_mc_pkg: opcode and funct localparams, FSM state enum (FETCH, DECODE, EXEC, MEM, WB, HALT), ALU operation encoding.
- Sub-module mips_mc_regfile: NREGS registers, two read ports plus the debug read port, one write port, async active-low clear.
- The FSM, datapath registers (IR, A, B, T, ALUOut, MDR, pc) and ALU live in the top module.

Test Plan:
- Reset with RESET_PC=32'h100, ready=1 -> first mem_addr=32'h100, pc_out=32'h104 after fetch; mid-FETCH reset drops mem_req the same cycle.
- addi r1,r0,5; addi r2,r0,7; sub r3,r1,r2; slt r4,r3,r0 -> r3=32'hFFFF_FFFE, r4=1; retire pulses 4 cycles apart.
- sw r2,8(r0) then lw r5,8(r0), with ready stuck low 3 cycles on each -> address/data stay stable during the stall; r5=7; lw takes 8 cycles.
- beq r1,r1,-1 -> pc back to the branch address after 3 cycles; bne r1,r1 not taken -> pc+4.
- jal to 32'h40 with NREGS=16 -> r15 = return address; jr r15 returns; an instruction naming r20 -> halted=1, fault=1, mem_req stays 0.
- lw from address 32'h6 -> fault=1 in EXEC, no MEM request issued; undefined opcode 111111 -> fault=1.
